// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if
//   Groups the receiver's line/tick inputs and its result outputs.
//   The slave modport is the receiver. The master modport is the side
//   that supplies the line and the tick and consumes the received word.
//   Signals:
//     tick       1-clk oversampling strobe, OVS per bit period
//     rx         serial line, idle high
//     dout       last received word
//     rx_done    1-clk pulse, dout/parity_o/errors valid
//     parity_o   received parity bit
//     parity_err parity mismatch on the last frame
//     frame_err  stop bit sampled low on the last frame
interface uart_rx_os_if #(
   parameter int DBITS = 3
);
   logic             tick;
   logic             rx;
   logic [DBITS-1:0] dout;
   logic             rx_done;
   logic             parity_o;
   logic             parity_err;
   logic             frame_err;

   modport master (
      output tick, rx,
      input  dout, rx_done, parity_o, parity_err, frame_err
   );

   modport slave (
      input  tick, rx,
      output dout, rx_done, parity_o, parity_err, frame_err
   );
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os
//   UART receiver using a 16x (OVS) oversampling tick. Frame layout:
//   start (0), DBITS data bits LSB first, optional parity, stop (1).
//   The word is presented on dout with a one-clock rx_done pulse, together
//   with the received parity bit and parity/framing error flags.
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> a parity bit follows the data bits and is checked
//     undefined -> no parity bit; parity_o and parity_err are tied to 0
//   Ports:
//     clk  system clock
//     rst  asynchronous reset, active-high
//     bus  uart_rx_os_if.slave (tick, rx in; dout, rx_done, parity_o,
//          parity_err, frame_err out)
module uart_rx_os #(
   parameter int DBITS      = 3,
   parameter int OVS        = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic         clk,
   input  logic         rst,
   uart_rx_os_if.slave  bus
);

   localparam int TCW = $clog2(OVS);
   localparam int BCW = (DBITS > 1) ? $clog2(DBITS) : 1;

   localparam logic [TCW-1:0] TICK_LAST = TCW'(OVS - 1);
   localparam logic [TCW-1:0] TICK_MID  = TCW'(OVS / 2 - 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(DBITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic [TCW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DBITS-1:0] shift_q, shift_d;
   logic [DBITS-1:0] dout_q, dout_d;
   logic             rx_done_q, rx_done_d;
   logic             frame_err_q, frame_err_d;
   logic             rx_meta_q, rx_sync_q;
   logic [DBITS-1:0] shift_in;
`ifdef UART_RX_PARITY_EN
   logic             parity_q, parity_d;
   logic             parity_o_q, parity_o_d;
   logic             parity_err_q, parity_err_d;
`endif

   // Two-flop synchronizer; rx is asynchronous to clk. Resets to the idle
   // level so a reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= bus.rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // New bits enter at the MSB so the first (LSB) bit ends up at bit 0.
   generate
      if (DBITS == 1) begin : g_shift_one
         assign shift_in = rx_sync_q;
      end else begin : g_shift_many
         assign shift_in = {rx_sync_q, shift_q[DBITS-1:1]};
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      tick_cnt_d   = tick_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      dout_d       = dout_q;
      rx_done_d    = 1'b0;
      frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
      parity_d     = parity_q;
      parity_o_d   = parity_o_q;
      parity_err_d = parity_err_q;
`endif

      case (state_q)
         S_IDLE: begin
            // Level-triggered: a line still low after a bad stop bit
            // immediately starts another frame (break handling).
            if (!rx_sync_q) begin
               state_d    = S_START;
               tick_cnt_d = '0;
            end
         end

         S_START: begin
            if (bus.tick) begin
               if (tick_cnt_q == TICK_MID) begin
                  tick_cnt_d = '0;
                  if (!rx_sync_q) begin
                     state_d   = S_DATA;
                     bit_cnt_d = '0;
                  end else begin
                     // Line went back high before mid start bit: glitch.
                     state_d = S_IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end

         S_DATA: begin
            if (bus.tick) begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  shift_d    = shift_in;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                     state_d   = S_PARITY;
`else
                     state_d   = S_STOP;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (bus.tick) begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  parity_d   = rx_sync_q;
                  state_d    = S_STOP;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
`endif

         S_STOP: begin
            if (bus.tick) begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d  = '0;
                  dout_d      = shift_q;
                  rx_done_d   = 1'b1;
                  // A bad stop bit is flagged but the word is still delivered.
                  frame_err_d = ~rx_sync_q;
`ifdef UART_RX_PARITY_EN
                  parity_o_d   = parity_q;
                  parity_err_d = (^shift_q) ^ parity_q ^ PARITY_ODD[0];
`endif
                  state_d     = S_IDLE;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d    = S_IDLE;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tick_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         dout_q       <= '0;
         rx_done_q    <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_q     <= 1'b0;
         parity_o_q   <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         dout_q       <= dout_d;
         rx_done_q    <= rx_done_d;
         frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         parity_q     <= parity_d;
         parity_o_q   <= parity_o_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign bus.dout       = dout_q;
   assign bus.rx_done    = rx_done_q;
   assign bus.frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_o   = parity_o_q;
   assign bus.parity_err = parity_err_q;
`else
   assign bus.parity_o   = 1'b0;
   assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os
//   Directed and randomized frames driven onto rx; every rx_done is recorded
//   by a monitor and compared with the word/flags the frame was built from.
module tb_uart_rx_os;

   localparam int DBITS      = 3;
   localparam int OVS        = 16;
   localparam int PARITY_ODD = 0;
   localparam int TDIV       = 4;   // clocks per oversampling tick
`ifdef UART_RX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   // Ticks from start detect to the stop-bit sample.
   localparam int FRAME_TICKS = OVS / 2 + OVS * (DBITS + PBITS + 1);

   typedef struct {
      logic [DBITS-1:0] d;
      logic             po;
      logic             pe;
      logic             fe;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tdiv = 0;
   int   total = 0;
   int   passed = 0;
   int   dbl_pulse = 0;
   logic prev_done = 1'b0;
   rec_t got_q[$];

   uart_rx_os_if #(.DBITS(DBITS)) rx_bus ();

   uart_rx_os #(.DBITS(DBITS), .OVS(OVS), .PARITY_ODD(PARITY_ODD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (rx_bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      rx_bus.tick = 1'b0;
      rx_bus.rx   = 1'b1;
   end

   // Free-running baud tick: one clock high every TDIV clocks.
   always @(negedge clk) begin
      tdiv = (tdiv == TDIV - 1) ? 0 : tdiv + 1;
      rx_bus.tick = (tdiv == 0);
   end

   // Record every completed frame and catch pulses longer than one clock.
   always @(negedge clk) begin
      rec_t r;
      if (rx_bus.rx_done) begin
         r.d  = rx_bus.dout;
         r.po = rx_bus.parity_o;
         r.pe = rx_bus.parity_err;
         r.fe = rx_bus.frame_err;
         got_q.push_back(r);
         if (prev_done) dbl_pulse <= dbl_pulse + 1;
      end
      prev_done <= rx_bus.rx_done;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic line_bit(input logic v, input int ticks);
      rx_bus.rx = v;
      repeat (ticks * TDIV) @(negedge clk);
   endtask

   // Transmitter model: start, data LSB first, optional parity, stop.
   // A bad stop bit is held low past its midpoint, then the line idles.
   task automatic send_frame(input logic [DBITS-1:0] d, input logic par, input logic stop_ok);
      line_bit(1'b0, OVS);
      for (int i = 0; i < DBITS; i++) line_bit(d[i], OVS);
`ifdef UART_RX_PARITY_EN
      line_bit(par, OVS);
`endif
      if (stop_ok) line_bit(1'b1, OVS);
      else begin
         line_bit(1'b0, OVS / 2 + 2);
         line_bit(1'b1, OVS / 2 - 2);
      end
      line_bit(1'b1, 2 * OVS);
   endtask

   // Expected result derived from the frame contents.
   task automatic expect_frame(input string tag, input logic [DBITS-1:0] d,
                               input logic par, input logic stop_ok);
      rec_t r;
      logic exp_po, exp_pe;
`ifdef UART_RX_PARITY_EN
      exp_po = par;
      exp_pe = ((^d) ^ par) != PARITY_ODD[0];
`else
      exp_po = 1'b0;
      exp_pe = 1'b0;
`endif
      chk({tag, ".count"}, got_q.size(), 1);
      if (got_q.size() > 0) begin
         r = got_q.pop_front();
         $display("frame %s: dout=%0h po=%0b pe=%0b fe=%0b", tag, r.d, r.po, r.pe, r.fe);
         chk({tag, ".dout"}, r.d, d);
         chk({tag, ".parity_o"}, r.po, exp_po);
         chk({tag, ".parity_err"}, r.pe, exp_pe);
         chk({tag, ".frame_err"}, r.fe, !stop_ok);
      end
      got_q.delete();
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, ".dout"}, rx_bus.dout, 0);
      chk({tag, ".rx_done"}, rx_bus.rx_done, 0);
      chk({tag, ".parity_o"}, rx_bus.parity_o, 0);
      chk({tag, ".parity_err"}, rx_bus.parity_err, 0);
      chk({tag, ".frame_err"}, rx_bus.frame_err, 0);
   endtask

   initial begin
      logic [DBITS-1:0] d;
      logic             par;
      logic             ok;
      logic [DBITS-1:0] held;
      int               n;

      // Reset with line idle.
      repeat (5) @(negedge clk);
      chk_outputs_zero("reset_active");
      rst = 1'b0;
      line_bit(1'b1, 200);
      chk("reset_idle.count", got_q.size(), 0);
      chk_outputs_zero("reset_idle");

      // Good word, correct even parity.
      send_frame(3'b101, 1'b0, 1'b1);
      expect_frame("good_101", 3'b101, 1'b0, 1'b1);

      // Same data with the wrong parity bit.
      send_frame(3'b101, 1'b1, 1'b1);
      expect_frame("badpar_101", 3'b101, 1'b1, 1'b1);

      // Framing error, then a clean frame.
      send_frame(3'b110, 1'b0, 1'b0);
      expect_frame("framing_110", 3'b110, 1'b0, 1'b0);
      send_frame(3'b110, 1'b0, 1'b1);
      expect_frame("after_framing_110", 3'b110, 1'b0, 1'b1);

      // Short low glitch must not produce a frame.
      held = rx_bus.dout;
      line_bit(1'b0, 4);
      line_bit(1'b1, 3 * OVS);
      chk("glitch.count", got_q.size(), 0);
      chk("glitch.dout", rx_bus.dout, held);

      // Break: line low for two frame times -> two all-zero frames with
      // frame_err; released before the third start bit is validated.
      line_bit(1'b0, 2 * FRAME_TICKS + 4);
      line_bit(1'b1, 3 * OVS);
      n = got_q.size();
      chk("break.count", n, 2);
      for (int i = 0; i < n; i++) begin
         $display("frame break[%0d]: dout=%0h fe=%0b pe=%0b", i, got_q[i].d, got_q[i].fe, got_q[i].pe);
         chk("break.dout", got_q[i].d, 0);
         chk("break.frame_err", got_q[i].fe, 1);
         chk("break.parity_err", got_q[i].pe, (PBITS == 1) ? PARITY_ODD : 0);
      end
      got_q.delete();

      // Load a non-zero word so the reset check below is meaningful.
      send_frame(3'b111, 1'b1, 1'b1);
      expect_frame("pre_reset_111", 3'b111, 1'b1, 1'b1);

      // Reset after two data bits of a frame.
      line_bit(1'b0, OVS);
      line_bit(1'b1, OVS);
      line_bit(1'b0, OVS);
      rst = 1'b1;
      rx_bus.rx = 1'b1;
      repeat (3) @(negedge clk);
      chk_outputs_zero("midframe_reset");
      rst = 1'b0;
      line_bit(1'b1, 4 * OVS);
      chk("midframe_reset.count", got_q.size(), 0);
      send_frame(3'b011, 1'b0, 1'b1);
      expect_frame("after_reset_011", 3'b011, 1'b0, 1'b1);

      // Randomized frames: random data, occasional wrong parity and bad stop.
      for (int k = 0; k < 10; k++) begin
         d   = DBITS'($urandom_range(0, (1 << DBITS) - 1));
         par = (^d) ^ PARITY_ODD[0] ^ ($urandom_range(0, 3) == 0);
         ok  = ($urandom_range(0, 3) != 0);
         send_frame(d, par, ok);
         expect_frame($sformatf("rand%0d", k), d, par, ok);
      end

      chk("rx_done_single_pulse", dbl_pulse, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
